// File: rtl/ahb_lite_sram_slave_if.sv
// rtl/ahb_lite_sram_slave_if.sv - AHB-Lite bus bundle between master/decoder and the SRAM slave
interface ahb_lite_sram_slave_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [1:0]  HTRANS;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;
   logic [15:0] err_count;

   modport slave (
      input  HSEL, HADDR, HWRITE, HSIZE, HTRANS, HWDATA, HREADY,
      output HREADYOUT, HRESP, HRDATA, err_count
   );

   modport master (
      output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HWDATA, HREADY,
      input  HREADYOUT, HRESP, HRDATA, err_count
   );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// rtl/ahb_lite_sram_slave.sv - AHB-Lite slave over a word RAM with wait states, byte lanes and ERROR response
module ahb_lite_sram_slave #(
   parameter int MEM_AW      = 8,
   parameter int WAIT_STATES = 0
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   ahb_lite_sram_slave_if.slave  bus
);
   localparam int DEPTH = 1 << MEM_AW;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WAIT = 3'd1;
   localparam logic [2:0] S_DATA = 3'd2;
   localparam logic [2:0] S_ERR1 = 3'd3;
   localparam logic [2:0] S_ERR2 = 3'd4;

   logic [31:0]       r_mem [DEPTH];
   logic [2:0]        r_state;
   logic [2:0]        w_next;
   logic [3:0]        r_wcnt;
   logic [MEM_AW+1:0] r_addr;
   logic [2:0]        r_size;
   logic              r_write;
   logic [15:0]       r_errs;
   logic              w_ready;
   logic              w_accept;
   logic              w_illegal;
   logic [2:0]        w_start;
   logic [3:0]        w_be;
   logic              w_unused;

   assign w_unused  = bus.HTRANS[0];
   assign w_ready   = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2);
   assign w_accept  = bus.HSEL && bus.HREADY && bus.HTRANS[1] && w_ready;
   assign w_illegal = (bus.HSIZE > 3'b010)
                    || ((bus.HSIZE == 3'b001) && bus.HADDR[0])
                    || ((bus.HSIZE == 3'b010) && (bus.HADDR[1:0] != 2'b00))
                    || (|bus.HADDR[31:MEM_AW+2]);
   assign w_start   = w_illegal ? S_ERR1 : ((WAIT_STATES > 0) ? S_WAIT : S_DATA);

   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_WAIT:  w_next = (r_wcnt == 4'd1) ? S_DATA : S_WAIT;
         S_ERR1:  w_next = S_ERR2;
         default: w_next = w_accept ? w_start : S_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state <= S_IDLE;
         r_wcnt  <= 4'd0;
         r_addr  <= '0;
         r_size  <= 3'd0;
         r_write <= 1'b0;
         r_errs  <= 16'd0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_addr  <= bus.HADDR[MEM_AW+1:0];
            r_size  <= bus.HSIZE;
            r_write <= bus.HWRITE;
            r_wcnt  <= 4'(WAIT_STATES);
         end else if (r_state == S_WAIT) begin
            r_wcnt <= r_wcnt - 4'd1;
         end
         if (w_accept && w_illegal && (r_errs != 16'hFFFF))
            r_errs <= r_errs + 16'd1;
      end
   end

   // Little-endian lane enables for the latched transfer.
   always_comb begin
      w_be = 4'b1111;
      case (r_size)
         3'b000:  w_be = 4'b0001 << r_addr[1:0];
         3'b001:  w_be = r_addr[1] ? 4'b1100 : 4'b0011;
         default: w_be = 4'b1111;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESETn && (r_state == S_DATA) && r_write) begin
         for (int i = 0; i < 4; i++)
            if (w_be[i])
               r_mem[r_addr[MEM_AW+1:2]][8*i +: 8] <= bus.HWDATA[8*i +: 8];
      end
   end

   assign bus.HREADYOUT = !((r_state == S_WAIT) || (r_state == S_ERR1));
   assign bus.HRESP     = (r_state == S_ERR1) || (r_state == S_ERR2);
   assign bus.HRDATA    = ((r_state == S_DATA) && !r_write) ? r_mem[r_addr[MEM_AW+1:2]] : 32'd0;
   assign bus.err_count = r_errs;
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb/tb_ahb_lite_sram_slave.sv - self-checking bench for ahb_lite_sram_slave (0 and 2 wait states)
module tb_ahb_lite_sram_slave;
   logic clk = 1'b0;
   logic rst_n;
   logic blk0, blk2;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   ahb_lite_sram_slave_if if0 ();
   ahb_lite_sram_slave_if if2 ();

   assign if0.HREADY = if0.HREADYOUT & ~blk0;
   assign if2.HREADY = if2.HREADYOUT & ~blk2;

   ahb_lite_sram_slave #(.MEM_AW(8), .WAIT_STATES(0)) u_dut0 (.HCLK(clk), .HRESETn(rst_n), .bus(if0.slave));
   ahb_lite_sram_slave #(.MEM_AW(8), .WAIT_STATES(2)) u_dut2 (.HCLK(clk), .HRESETn(rst_n), .bus(if2.slave));

   virtual ahb_lite_sram_slave_if vif;

   logic [7:0] mdl [2][1024];
   int         exp_err [2];
   int         ws [2] = '{0, 2};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pick(input int d);
      if (d == 0) vif = if0;
      else        vif = if2;
   endtask

   task automatic idle_bus();
      vif.HSEL = 1'b0; vif.HTRANS = 2'b00; vif.HADDR = 32'd0;
      vif.HWRITE = 1'b0; vif.HSIZE = 3'd0; vif.HWDATA = 32'd0;
   endtask

   function automatic logic [31:0] mword(input int d, input int a);
      int b = a & ~3;
      return {mdl[d][b+3], mdl[d][b+2], mdl[d][b+1], mdl[d][b]};
   endfunction

   // One non-pipelined transfer, checked against the byte-level model.
   task automatic xfer(input int d, input logic wr, input logic [2:0] sz,
                       input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] rd);
      bit          legal;
      int          lows, nbytes;
      logic        bad_low, resp;
      logic [31:0] exp_rd;
      legal = !((sz > 3'd2) || (sz == 3'd1 && addr[0]) || (sz == 3'd2 && addr[1:0] != 2'b00) || (addr >= 32'd1024));
      exp_rd = (legal && !wr) ? mword(d, int'(addr)) : 32'd0;
      pick(d);
      @(negedge clk);
      vif.HSEL = 1'b1; vif.HTRANS = 2'b10; vif.HADDR = addr; vif.HWRITE = wr; vif.HSIZE = sz;
      @(posedge clk); #1;
      idle_bus();
      vif.HWDATA = wd;
      lows = 0; bad_low = 1'b0;
      while (vif.HREADYOUT !== 1'b1 && lows < 20) begin
         if (vif.HRESP !== !legal) bad_low = 1'b1;
         lows++;
         @(posedge clk); #1;
      end
      rd   = vif.HRDATA;
      resp = vif.HRESP;
      @(posedge clk); #1;
      vif.HWDATA = 32'd0;
      if (legal && wr) begin
         nbytes = 1 << sz;
         for (int i = 0; i < nbytes; i++)
            mdl[d][int'(addr) + i] = wd[8*((int'(addr) + i) % 4) +: 8];
      end
      if (!legal) exp_err[d]++;
      chk("low_cycles", lows, legal ? ws[d] : 1);
      chk("resp_low", bad_low, 1'b0);
      chk("resp_final", resp, !legal);
      chk("rdata", rd, exp_rd);
      chk("err_count", vif.err_count, exp_err[d]);
   endtask

   task automatic nop_cycle(input string tag, input logic sel, input logic [1:0] tr, input logic b);
      pick(0);
      @(negedge clk);
      vif.HSEL = sel; vif.HTRANS = tr; vif.HADDR = 32'h0; vif.HWRITE = 1'b1;
      vif.HSIZE = 3'd2; vif.HWDATA = 32'hDEAD_BEEF; blk0 = b;
      @(posedge clk); #1;
      idle_bus();
      vif.HWDATA = 32'hCAFE_F00D;
      blk0 = 1'b0;
      chk({tag, "_rdy"}, vif.HREADYOUT, 1'b1);
      chk({tag, "_resp"}, vif.HRESP, 1'b0);
      chk({tag, "_rdata"}, vif.HRDATA, 32'd0);
      @(posedge clk); #1;
      vif.HWDATA = 32'd0;
      chk({tag, "_err"}, vif.err_count, exp_err[0]);
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] a;
      logic [2:0]  s;
      blk0 = 1'b0; blk2 = 1'b0;
      exp_err[0] = 0; exp_err[1] = 0;
      pick(0); idle_bus();
      pick(1); idle_bus();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdy0", if0.HREADYOUT, 1'b1);
      chk("rst_resp0", if0.HRESP, 1'b0);
      chk("rst_rdata0", if0.HRDATA, 32'd0);
      chk("rst_err0", if0.err_count, 16'd0);
      chk("rst_rdy2", if2.HREADYOUT, 1'b1);
      @(negedge clk); rst_n = 1'b1;

      for (int d = 0; d < 2; d++)
         for (int w = 0; w < 16; w++)
            xfer(d, 1'b1, 3'd2, 32'(w * 4), $urandom, rd);

      // Reset while dut2 is in its wait cycles, with a nonzero error count.
      xfer(1, 1'b1, 3'd3, 32'h0, 32'h0, rd);
      pick(1);
      @(negedge clk);
      vif.HSEL = 1'b1; vif.HTRANS = 2'b10; vif.HADDR = 32'h4; vif.HWRITE = 1'b0; vif.HSIZE = 3'd2;
      @(posedge clk); #1;
      idle_bus();
      chk("midwait_rdy", vif.HREADYOUT, 1'b0);
      rst_n = 1'b0;
      #1;
      exp_err[0] = 0; exp_err[1] = 0;
      chk("midrst_rdy", if2.HREADYOUT, 1'b1);
      chk("midrst_resp", if2.HRESP, 1'b0);
      chk("midrst_rdata", if2.HRDATA, 32'd0);
      chk("midrst_err", if2.err_count, 16'd0);
      @(negedge clk); rst_n = 1'b1;

      // Pipelined write then read on the zero-wait slave.
      pick(0);
      @(negedge clk);
      vif.HSEL = 1'b1; vif.HTRANS = 2'b10; vif.HADDR = 32'h0; vif.HWRITE = 1'b1; vif.HSIZE = 3'd2;
      @(posedge clk); #1;
      vif.HWDATA = 32'h0000_AABB; vif.HWRITE = 1'b0;
      chk("pipe_wr_rdy", vif.HREADYOUT, 1'b1);
      chk("pipe_wr_resp", vif.HRESP, 1'b0);
      @(posedge clk); #1;
      idle_bus();
      chk("pipe_rd_rdy", vif.HREADYOUT, 1'b1);
      chk("pipe_rd_resp", vif.HRESP, 1'b0);
      chk("pipe_rd_data", vif.HRDATA, 32'h0000_AABB);
      @(posedge clk); #1;
      mdl[0][0] = 8'hBB; mdl[0][1] = 8'hAA; mdl[0][2] = 8'h00; mdl[0][3] = 8'h00;

      xfer(1, 1'b0, 3'd2, 32'h4, 32'h0, rd);

      for (int d = 0; d < 2; d++) begin
         xfer(d, 1'b1, 3'd2, 32'h8, 32'hFFFF_FFFF, rd);
         xfer(d, 1'b1, 3'd0, 32'hA, 32'h00AA_0000, rd);
         xfer(d, 1'b0, 3'd2, 32'h8, 32'h0, rd);
         chk("lane_merge", rd, 32'hFFAA_FFFF);
      end

      xfer(0, 1'b1, 3'd2, 32'h2, 32'h1234_5678, rd);
      chk("err_one", if0.err_count, 16'd1);
      xfer(0, 1'b0, 3'd2, 32'h0, 32'h0, rd);
      chk("err_nowrite", rd, 32'h0000_AABB);
      xfer(0, 1'b1, 3'd2, 32'h0001_0000, 32'h1, rd);
      chk("err_two", if0.err_count, 16'd2);

      nop_cycle("hsel0", 1'b0, 2'b10, 1'b0);
      nop_cycle("idle", 1'b1, 2'b00, 1'b0);
      nop_cycle("busy", 1'b1, 2'b01, 1'b0);
      nop_cycle("hrdy0", 1'b1, 2'b10, 1'b1);
      xfer(0, 1'b0, 3'd2, 32'h0, 32'h0, rd);
      chk("nop_nowrite", rd, 32'h0000_AABB);

      for (int n = 0; n < 200; n++) begin
         a = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 9) == 0) a = 32'h0000_0400 + 32'($urandom_range(0, 4095));
         s = 3'($urandom_range(0, 3));
         xfer(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), s, a, $urandom, rd);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
